// File: rtl/dct2_transpose_buf.sv
// Single-bank transpose buffer between the two 1-D DCT-II passes.
// Rows of an SxS block are written in, then read back out as columns.
module dct2_transpose_buf #(
    parameter int DW   = 16,
    parameter int MAXS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAXS*DW-1:0]   row_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAXS*DW-1:0]   col_out,
    output logic [1:0]           out_n,
    output logic                 out_last
);

    localparam int CW = $clog2(MAXS);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   row_cnt_q;
    logic [CW-1:0]   col_cnt_q;
    logic [1:0]      blk_n_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic [DW-1:0]   mem_q [MAXS][MAXS];

    logic [1:0]      wr_n;
    logic [CW-1:0]   wr_last;
    logic [CW-1:0]   rd_last;
    logic            row_acc;
    logic            col_acc;

    // Highest lane/row index for size code n (S-1, S = 4<<n).
    function automatic logic [CW-1:0] last_idx(input logic [1:0] n);
        logic [CW:0] s;
        s = (CW+1)'(4) << n;
        return CW'(s - 1'b1);
    endfunction

    // The first row of a block takes its size from the live N input.
    assign wr_n    = (row_cnt_q == '0) ? N : blk_n_q;
    assign wr_last = last_idx(wr_n);
    assign rd_last = last_idx(blk_n_q);
    assign row_acc = in_valid && in_ready_q;
    assign col_acc = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            blk_n_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (row_acc) begin
                        if (row_cnt_q == '0)
                            blk_n_q <= N;
                        if (row_cnt_q == wr_last) begin
                            row_cnt_q   <= '0;
                            state_q     <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end else begin
                            row_cnt_q <= row_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (col_acc) begin
                        if (col_cnt_q == rd_last) begin
                            col_cnt_q   <= '0;
                            state_q     <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end else begin
                            col_cnt_q  <= col_cnt_q + 1'b1;
                            out_last_q <= ((col_cnt_q + 1'b1) == rd_last);
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    // Storage needs no reset: a block only reads locations it wrote.
    always_ff @(posedge clk) begin
        if (row_acc) begin
            for (int k = 0; k < MAXS; k++) begin
                if (CW'(k) <= wr_last)
                    mem_q[row_cnt_q][k] <= row_in[k*DW +: DW];
            end
        end
    end

    always_comb begin
        col_out = '0;
        if (out_valid_q) begin
            for (int r = 0; r < MAXS; r++) begin
                if (CW'(r) <= rd_last)
                    col_out[r*DW +: DW] = mem_q[r][col_cnt_q];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_n     = blk_n_q;

endmodule

// File: tb/tb_dct2_transpose_buf.sv
// Scoreboard bench for dct2_transpose_buf: expected columns come from
// a plain matrix transpose of the rows the driver sends.
module tb_dct2_transpose_buf;

    localparam int DW   = 16;
    localparam int MAXS = 32;
    localparam int W    = DW * MAXS;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     n_in;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   row_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   col_out;
    logic [1:0]     out_n;
    logic           out_last;

    dct2_transpose_buf #(.DW(DW), .MAXS(MAXS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .N         (n_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_in    (row_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .col_out   (col_out),
        .out_n     (out_n),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] col;
        logic [1:0]   n;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           col_seen = 0;
    int           rdy_mode = 0;
    int           phase = 0;
    bit           stalled = 0;
    logic [W-1:0] h_col;
    logic [1:0]   h_n;
    logic         h_last;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    out_ready = (phase % 3) == 0;
                    phase++;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: handshakes are sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            check("ready_vs_valid", in_ready, !out_valid);
            if (out_valid) begin
                if (stalled) begin
                    check("hold_col", col_out, h_col);
                    check("hold_n", out_n, h_n);
                    check("hold_last", out_last, h_last);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_column actual=%0h expected=none",
                                 col_out);
                    end else begin
                        e = sb.pop_front();
                        check("col", col_out, e.col);
                        check("out_n", out_n, e.n);
                        check("out_last", out_last, e.last);
                    end
                    col_seen++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    h_col   = col_out;
                    h_n     = out_n;
                    h_last  = out_last;
                end
            end else begin
                stalled = 0;
            end
        end
    end

    task automatic drive_row(input logic [1:0] n, input logic [W-1:0] row);
        int t;
        t = 0;
        in_valid = 1'b1;
        n_in     = n;
        row_in   = row;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                checks++;
                errors++;
                $display("FAIL row_timeout actual=0 expected=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // mode: 0 random, 1 10r+k, 2 32r+k, 3 +/-1 checkerboard
    task automatic run_block(input logic [1:0] n0, input int mode,
                             input int chg_row, input logic [1:0] n1);
        logic [DW-1:0] m [MAXS][MAXS];
        logic [W-1:0]  row;
        logic [1:0]    nr;
        exp_t          x;
        int            s;
        s = 4 << n0;
        for (int r = 0; r < MAXS; r++)
            for (int k = 0; k < MAXS; k++)
                case (mode)
                    1: m[r][k] = DW'(10 * r + k);
                    2: m[r][k] = DW'(r * 32 + k);
                    3: m[r][k] = ((r + k) % 2 == 1) ? 16'hFFFF : 16'h0001;
                    default: m[r][k] = DW'($urandom);
                endcase
        for (int c = 0; c < s; c++) begin
            x.col = '0;
            for (int r = 0; r < s; r++)
                x.col[r*DW +: DW] = m[r][c];
            x.n    = n0;
            x.last = (c == s - 1);
            sb.push_back(x);
        end
        for (int r = 0; r < s; r++) begin
            for (int k = 0; k < MAXS; k++)
                row[k*DW +: DW] = m[r][k];
            nr = (chg_row >= 0 && r > chg_row) ? n1 : n0;
            drive_row(nr, row);
        end
    endtask

    task automatic wait_empty();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", sb.size());
        end
    endtask

    initial begin
        int c0;
        int base;
        int t;
        in_valid = 1'b0;
        n_in     = 2'b00;
        row_in   = '0;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_n", out_n, 2'b00);
        check("rst_col_out", col_out, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        rdy_mode = 0;
        run_block(2'b00, 1, -1, 2'b00);
        wait_empty();

        c0 = cyc;
        run_block(2'b11, 2, -1, 2'b00);
        check("fill_cycles", W'(cyc - c0), W'(32));
        check("first_valid_lat", out_valid, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        check("drain_done_valid", out_valid, 1'b0);
        check("drain_done_ready", in_ready, 1'b1);
        check("drain_done_sb", W'(sb.size()), '0);

        rdy_mode = 1;
        run_block(2'b01, 0, -1, 2'b00);
        wait_empty();

        rdy_mode = 0;
        run_block(2'b01, 0, 2, 2'b10);
        run_block(2'b10, 0, -1, 2'b10);
        wait_empty();

        base = col_seen;
        run_block(2'b10, 0, -1, 2'b10);
        t = 0;
        while (col_seen < base + 5 && t < 200) begin
            @(posedge clk);
            t++;
        end
        check("reach_col5", W'(col_seen >= base + 5), W'(1));
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_col_out", col_out, '0);
        check("abort_out_last", out_last, 1'b0);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        run_block(2'b10, 3, -1, 2'b10);
        wait_empty();

        rdy_mode = 2;
        for (int b = 0; b < 6; b++)
            run_block(2'($urandom_range(0, 3)), 0,
                      int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        wait_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
